rs_encoder_t16: RTL and testbench
=================================

Name: rs_encoder_t16

Overview:
Systematic RS(255,223) encoder over GF(2^8), t=16, byte-serial. It is the transmit-side counterpart of the t=16 decoder chain (syndrome, key equation, Chien/omega evaluation). It passes 223 message bytes through unchanged, then emits 32 parity bytes computed by a 32-stage GF(2^8) LFSR. Its field and generator conventions match the decoder exactly.

Parameters:
N, 255, codeword length in bytes
K, 223, message length in bytes
NPAR, 32, parity bytes (2T); fixed by the generator table, and must satisfy N-K
FCR, 0, first consecutive root; g(x) = prod_{i=FCR}^{FCR+31} (x - alpha^i)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-low reset
in_data  in  8  message byte
in_valid  in  1  in_data valid
in_sop  in  1  marks first message byte of a codeword
in_ready  out  1  encoder accepts in_data this cycle
out_data  out  8  codeword byte
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
out_sop  out  1  first byte of codeword
out_eop  out  1  last parity byte
out_par  out  1  out_data is a parity byte
proto_err  out  1  one-cycle pulse: in_sop seen mid-message

Behaviour:
- Field: primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02. This is identical to the decoder.
- Generator: g(x) = x^32 + g31 x^31 + ... + g0, monic.
- Reset (reset=0 at a clk edge, any state, including mid-codeword):
  - state = IDLE, all 32 LFSR regs r[0..31] = 0, counter = 0.
  - out_data = 0; out_valid, out_sop, out_eop, out_par, proto_err all = 0.
  - Any partial codeword is discarded.
- Output register: one entry, 1-cycle latency from input accept to out_valid.
- Output register is free when !out_valid || out_ready. A held output (out_valid && !out_ready) keeps data and all flags stable.
- in_ready = free && (state==IDLE || state==MSG). It is 0 in PAR.
- Accept event = in_valid && in_ready.
- States:
  - IDLE:
    - Accept with in_sop=1: fb = in_data (regs treated as zero). Load r[0] = g0*fb and r[i] = g_i*fb. Output the byte with out_sop=1. Counter = 1, go to MSG.
    - Accept with in_sop=0: byte is dropped, nothing is output, stay in IDLE.
  - MSG:
    - Each accept: fb = in_data ^ r[31]. Update r[0] <= g0*fb and r[i] <= r[i-1] ^ g_i*fb. Output in_data with out_par=0. Counter increments.
    - in_sop=1 in MSG: the byte is treated as data and proto_err pulses.
    - When the accepted byte is the K-th (counter==K-1): counter = 0, go to PAR.
  - PAR: each cycle that the output is free:
    - Output r[31] with out_par=1, then shift r[i] <= r[i-1], r[0] <= 0, counter increments.
    - The 32nd parity byte carries out_eop=1 and the next state is IDLE.
    - Parity order is highest degree first (r31 .. r0).
- Throughput: an sop byte is accepted in the cycle after the eop byte is loaded. Back-to-back codewords have no bubble beyond the IDLE accept.
- Counter is 8 bits, wide enough for 0..K-1, with no wrap within a codeword.
- Simultaneous reset and accept: reset wins.
- Simultaneous out_ready=0 and a pending accept: in_ready is already 0, so there is no loss.
- GF multiply by a constant is pure XOR logic. All state updates happen only on accept (MSG) or free (PAR).

Decomposition:
- Package rs_t16_pkg holds:
  - GF_PRIM = 9'h11D, N, K, NPAR, FCR.
  - The constant table G[0:31] (generator coefficients), generated offline by the team script for 0x11D and FCR=0.
  - State enum IDLE/MSG/PAR.
- Sub-module rs_enc_cmul: parameter C[7:0], input b[7:0], output p = C*b in GF(2^8), purely combinational. It is instantiated 32 times, once per g_i. The g_i==0 and g_i==1 cases reduce trivially.

Test Plan:
- All-zero message (223 × 0x00, sop on first) -> 223 × 0x00 passed through, then 32 × 0x00 parity; out_sop on byte 0, out_eop on byte 254.
- Message 222 × 0x00 then 0x01 -> parity bytes equal g31, g30, ..., g0 from the package table, in that order; g0 == alpha^241.
- Random messages checked against the golden C model; each codeword also fed to the t=16 decoder model -> all syndromes zero.
- out_ready held low 5 cycles at parity byte 10 -> out_data/out_par frozen, in_ready=0, no byte lost or duplicated, 255 bytes total.
- Reset asserted at message byte 100, then a new codeword -> outputs 0 on the cycle after reset; the new codeword's parity matches the model with no residue from the aborted one.
- Two codewords back-to-back plus a spurious in_sop at message byte 50 -> proto_err single pulse, byte treated as data, both codewords correct, second sop accepted immediately after first eop.

Source files
------------

// File: rtl/rs_t16_pkg.sv
// Shared constants, state encoding and GF(2^8) helpers for the RS(255,223) t=16 encoder.
// The field and generator conventions are the same ones the t=16 decoder chain uses.
package rs_t16_pkg;

  localparam logic [8:0]  GF_PRIM = 9'h11D;
  localparam int unsigned N       = 255;
  localparam int unsigned K       = 223;
  localparam int unsigned NPAR    = 32;
  localparam int unsigned FCR     = 0;

  typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x[7] ? ((x << 1) ^ GF_PRIM[7:0]) : (x << 1);
    end
    return acc;
  endfunction

  // Expands prod (x - alpha^i), i = FCR..FCR+NPAR-1; the monic x^NPAR term is implicit.
  function automatic logic [NPAR-1:0][7:0] gen_poly();
    logic [7:0]            c [0:NPAR];
    logic [7:0]            root;
    logic [NPAR-1:0][7:0]  g;
    for (int unsigned j = 0; j <= NPAR; j++) c[j] = '0;
    c[0] = 8'h01;
    root = 8'h01;
    for (int unsigned k = 0; k < FCR; k++) root = gf_mul(root, 8'h02);
    for (int unsigned i = 0; i < NPAR; i++) begin
      for (int unsigned j = i + 1; j > 0; j--) c[j] = c[j-1] ^ gf_mul(c[j], root);
      c[0] = gf_mul(c[0], root);
      root = gf_mul(root, 8'h02);
    end
    for (int unsigned j = 0; j < NPAR; j++) g[j] = c[j];
    return g;
  endfunction

  localparam logic [NPAR-1:0][7:0] G = gen_poly();

endpackage

// File: rtl/rs_enc_cmul.sv
// Constant multiplier p = C*b in GF(2^8); folds to a fixed XOR network per output bit.
module rs_enc_cmul
  import rs_t16_pkg::*;
#(
  parameter logic [7:0] C = 8'h01
) (
  input  logic [7:0] b,
  output logic [7:0] p
);

  if (C == 8'h01) begin : g_unity
    assign p = b;
  end else begin : g_xor
    always_comb begin
      p = '0;
      for (int unsigned i = 0; i < 8; i++) begin
        if (b[i]) p = p ^ gf_mul(C, 8'(1 << i));
      end
    end
  end

endmodule

// File: rtl/rs_encoder_t16.sv
// Byte-serial systematic RS(255,223) encoder: 223 message bytes pass through, then 32
// parity bytes (highest degree first) from a 32-stage LFSR, behind a one-entry output register.
module rs_encoder_t16
  import rs_t16_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_sop,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sop,
  output logic       out_eop,
  output logic       out_par,
  output logic       proto_err
);

  localparam logic [7:0] K_LAST = 8'(K - 1);
  localparam logic [7:0] P_LAST = 8'(NPAR - 1);

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic [7:0] r   [NPAR];
  logic [7:0] gfb [NPAR];
  logic [7:0] fb;
  logic       free, accept;
  logic       load_msg, shift_par;
  logic       emit, emit_sop, emit_eop, emit_par;
  logic [7:0] emit_data;

  assign free     = !out_valid || out_ready;
  assign in_ready = free && (state != PAR);
  assign accept   = in_valid && in_ready;
  // In IDLE the registers are treated as zero, so feedback is the raw byte.
  assign fb       = in_data ^ ((state == MSG) ? r[NPAR-1] : 8'h00);

  for (genvar i = 0; i < NPAR; i++) begin : g_cmul
    rs_enc_cmul #(.C(G[i])) u_cmul (.b(fb), .p(gfb[i]));
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_msg   = 1'b0;
    shift_par  = 1'b0;
    emit       = 1'b0;
    emit_data  = in_data;
    emit_sop   = 1'b0;
    emit_eop   = 1'b0;
    emit_par   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && in_sop) begin
          load_msg   = 1'b1;
          emit       = 1'b1;
          emit_sop   = 1'b1;
          cnt_next   = 8'd1;
          state_next = MSG;
        end
      end
      MSG: begin
        if (accept) begin
          load_msg = 1'b1;
          emit     = 1'b1;
          if (cnt == K_LAST) begin
            cnt_next   = '0;
            state_next = PAR;
          end else begin
            cnt_next = cnt + 8'd1;
          end
        end
      end
      PAR: begin
        if (free) begin
          shift_par = 1'b1;
          emit      = 1'b1;
          emit_data = r[NPAR-1];
          emit_par  = 1'b1;
          if (cnt == P_LAST) begin
            emit_eop   = 1'b1;
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt + 8'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      for (int unsigned i = 0; i < NPAR; i++) r[i] <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_par   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      proto_err <= accept && (state == MSG) && in_sop;
      if (load_msg) begin
        r[0] <= gfb[0];
        for (int unsigned i = 1; i < NPAR; i++)
          r[i] <= ((state == MSG) ? r[i-1] : 8'h00) ^ gfb[i];
      end else if (shift_par) begin
        r[0] <= '0;
        for (int unsigned i = 1; i < NPAR; i++) r[i] <= r[i-1];
      end
      if (free) begin
        out_valid <= emit;
        out_sop   <= emit_sop;
        out_eop   <= emit_eop;
        out_par   <= emit_par;
        if (emit) out_data <= emit_data;
      end
    end
  end

endmodule

// File: tb/tb_rs_encoder_t16.sv
// Directed bench for rs_encoder_t16: log/antilog GF model, long-division parity and syndrome checks.
module tb_rs_encoder_t16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_sop = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_sop, out_eop, out_par, proto_err;

  rs_encoder_t16 dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_par(out_par), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int perr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  cap_data [$];
  logic [2:0]  cap_flag [$];
  int unsigned cap_cyc  [$];

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      cap_data.push_back(out_data);
      cap_flag.push_back({out_sop, out_eop, out_par});
      cap_cyc.push_back(cyc);
    end
    if (proto_err) perr_cnt++;
  end

  logic [7:0] gexp [0:254];
  int         glog [0:255];
  logic [7:0] gen  [0:32];
  logic [7:0] msgs [0:1][0:222];
  logic [7:0] par_exp [0:31];

  typedef struct { string name; int pos; logic [7:0] exp; } vec_t;
  vec_t vecs [8];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic build_field();
    int e = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = 8'(e);
      glog[e] = i;
      e = e << 1;
      if (e & 'h100) e = e ^ 'h11D;
    end
    for (int j = 0; j <= 32; j++) gen[j] = 8'h00;
    gen[0] = 8'h01;
    for (int r = 0; r < 32; r++) begin
      for (int j = r + 1; j >= 1; j--) gen[j] = gen[j-1] ^ gmul(gen[j], gexp[r]);
      gen[0] = gmul(gen[0], gexp[r]);
    end
  endtask

  task automatic model_parity(input int which);
    logic [7:0] p [0:254];
    logic [7:0] coef;
    for (int j = 0; j < 32; j++) p[j] = 8'h00;
    for (int i = 0; i < 223; i++) p[254-i] = msgs[which][i];
    for (int d = 254; d >= 32; d--) begin
      coef = p[d];
      if (coef != 8'h00)
        for (int i = 0; i <= 32; i++) p[d-32+i] = p[d-32+i] ^ gmul(coef, gen[i]);
    end
    for (int j = 0; j < 32; j++) par_exp[j] = p[31-j];
  endtask

  task automatic check_codeword(input string name, input int which, input int base);
    logic [7:0] s;
    logic [7:0] exp_d;
    if (cap_data.size() < base + 255) begin
      chk({name, "_size"}, cap_data.size(), base + 255);
      return;
    end
    model_parity(which);
    for (int i = 0; i < 255; i++) begin
      exp_d = (i < 223) ? msgs[which][i] : par_exp[i-223];
      chk($sformatf("%s_data[%0d]", name, i), cap_data[base+i], exp_d);
      chk($sformatf("%s_flags[%0d]", name, i), cap_flag[base+i],
          {(i == 0), (i == 254), (i >= 223)});
    end
    for (int j = 0; j < 32; j++) begin
      s = 8'h00;
      for (int k = 0; k < 255; k++) s = gmul(s, gexp[j]) ^ cap_data[base+k];
      chk($sformatf("%s_syn[%0d]", name, j), s, 8'h00);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic sop);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = sop;
    @(negedge clk);
    while (!in_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic send_msg(input int which, input int nbytes, input int spur);
    for (int i = 0; i < nbytes; i++) send_byte(msgs[which][i], (i == 0) || (i == spur));
  endtask

  task automatic wait_bytes(input int n);
    int t = 0;
    while (cap_data.size() < n && t < 5000) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (cap_data.size() < n) chk("output_timeout", cap_data.size(), n);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_caps();
    cap_data.delete();
    cap_flag.delete();
    cap_cyc.delete();
  endtask

  task automatic rand_msg(input int which);
    for (int i = 0; i < 223; i++) msgs[which][i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    build_field();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_flags", {out_sop, out_eop, out_par}, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Byte without sop in IDLE is dropped
    send_byte(8'hAA, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_drop_count", cap_data.size(), 0);
    chk("idle_drop_valid", out_valid, 0);

    // All-zero message
    for (int i = 0; i < 223; i++) msgs[0][i] = 8'h00;
    clear_caps();
    send_msg(0, 223, -1);
    wait_bytes(255);
    chk("zero_size", cap_data.size(), 255);
    check_codeword("zero", 0, 0);

    // Single trailing 1: parity equals generator coefficients g31..g0
    msgs[0][222] = 8'h01;
    vecs[0] = '{"msg_first", 0,   8'h00};
    vecs[1] = '{"msg_last",  222, 8'h01};
    vecs[2] = '{"g31",       223, gen[31]};
    vecs[3] = '{"g30",       224, gen[30]};
    vecs[4] = '{"g16",       238, gen[16]};
    vecs[5] = '{"g1",        253, gen[1]};
    vecs[6] = '{"g0",        254, gen[0]};
    vecs[7] = '{"g0_alpha241", 254, gexp[241]};
    clear_caps();
    send_msg(0, 223, -1);
    wait_bytes(255);
    for (int v = 0; v < 8; v++) begin
      if (cap_data.size() > vecs[v].pos)
        chk(vecs[v].name, cap_data[vecs[v].pos], vecs[v].exp);
      else
        chk({vecs[v].name, "_missing"}, cap_data.size(), vecs[v].pos + 1);
    end
    check_codeword("unit", 0, 0);

    // Random messages
    for (int n = 0; n < 2; n++) begin
      rand_msg(0);
      clear_caps();
      send_msg(0, 223, -1);
      wait_bytes(255);
      check_codeword($sformatf("rand%0d", n), 0, 0);
    end

    // Backpressure at parity byte 10
    rand_msg(0);
    model_parity(0);
    clear_caps();
    send_msg(0, 223, -1);
    begin
      int t = 0;
      while (cap_data.size() < 233 && t < 1000) begin
        @(negedge clk);
        #1;
        t++;
      end
      chk("bp_reach", cap_data.size(), 233);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_valid[%0d]", c), out_valid, 1);
      chk($sformatf("bp_par[%0d]", c), out_par, 1);
      chk($sformatf("bp_data[%0d]", c), out_data, par_exp[10]);
      chk($sformatf("bp_in_ready[%0d]", c), in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_bytes(255);
    chk("bp_size", cap_data.size(), 255);
    check_codeword("bp", 0, 0);

    // Reset at message byte 100, coinciding with a valid byte
    rand_msg(0);
    send_msg(0, 100, -1);
    in_valid = 1'b1;
    in_data  = msgs[0][100];
    reset    = 1'b0;
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_flags", {out_sop, out_eop, out_par, proto_err}, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    rand_msg(0);
    clear_caps();
    send_msg(0, 223, -1);
    wait_bytes(255);
    chk("post_rst_size", cap_data.size(), 255);
    check_codeword("post_rst", 0, 0);

    // Back-to-back codewords with a spurious sop at byte 50
    chk("no_proto_err_so_far", perr_cnt, 0);
    rand_msg(0);
    rand_msg(1);
    perr_cnt = 0;
    clear_caps();
    send_msg(0, 223, 50);
    send_msg(1, 223, -1);
    wait_bytes(510);
    chk("b2b_size", cap_data.size(), 510);
    check_codeword("b2b0", 0, 0);
    check_codeword("b2b1", 1, 255);
    chk("b2b_proto_err_pulses", perr_cnt, 1);
    if (cap_cyc.size() >= 256)
      chk("b2b_sop_gap", cap_cyc[255] - cap_cyc[254], 1);
    else
      chk("b2b_sop_gap_missing", cap_cyc.size(), 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
